queue_desc_buffer: RTL and testbench
====================================

QUEUE_DESC_BUFFER -- requirements
Module: queue_desc_buffer

Interface
REQ-001 Parameter NUM_Q, default 8: number of per-queue descriptor FIFOs.
REQ-002 Parameter DEPTH, default 8: entries per FIFO; SHALL be a power of two.
REQ-003 Parameter ADDR_W, default 16: buffer-memory address width.
REQ-004 clk_in  input  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 desc_i  input  24  enqueue descriptor {queue_number[7:0], bm_address[15:0]}.
REQ-007 desc_vld_i  input  1  desc_i valid.
REQ-008 desc_rdy_o  output  1  block accepting descriptors.
REQ-009 deq_req_i  input  1  dequeue request, one cycle per request.
REQ-010 deq_queue_i  input  3  queue selected for dequeue.
REQ-011 deq_vld_o  output  1  one-cycle pulse: deq_address_o/deq_queue_o valid.
REQ-012 deq_address_o  output  16  dequeued bm_address.
REQ-013 deq_queue_o  output  3  queue the address came from.
REQ-014 deq_err_o  output  1  one-cycle pulse: dequeue of an empty queue.
REQ-015 queue_nonempty_o  output  8  bit q SHALL be 1 when FIFO q holds at least one entry.
REQ-016 drop_cnt_o  output  16  count of dropped descriptors, saturating.

Function
REQ-017 desc_rdy_o SHALL be 1 whenever rst_n is high; a transfer occurs when desc_vld_i and desc_rdy_o are both high at a clock edge.
REQ-018 An accepted descriptor with queue_number < NUM_Q SHALL be written to FIFO queue_number[2:0], provided that FIFO was not full before the edge.
REQ-019 An accepted descriptor with queue_number >= NUM_Q, or one targeting a FIFO that was full before the edge, SHALL be dropped, and drop_cnt_o SHALL increment by 1.
REQ-020 drop_cnt_o SHALL saturate at 16'hFFFF and never wrap.
REQ-021 Full is evaluated on pre-edge occupancy, so a simultaneous dequeue from a full FIFO SHALL NOT admit that cycle's enqueue; the enqueue is dropped.
REQ-022 When deq_req_i is high and FIFO deq_queue_i is non-empty before the edge, the head entry SHALL be popped.
REQ-023 For that pop, in the next cycle: deq_vld_o=1, deq_address_o=head address, deq_queue_o=deq_queue_i (latency 1).
REQ-024 deq_req_i to an empty FIFO SHALL pop nothing and SHALL pulse deq_err_o in the next cycle with deq_vld_o=0.
REQ-025 No bypass: an enqueue and a dequeue to the same empty FIFO in one cycle SHALL produce deq_err_o, and the entry SHALL remain stored.
REQ-026 Enqueue and dequeue to different queues, or to the same non-empty, non-full queue, in one cycle SHALL both complete; that queue's occupancy is unchanged.
REQ-027 Each FIFO SHALL use read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits (range 0..DEPTH).
REQ-028 Order within each queue SHALL be strictly FIFO.
REQ-029 deq_address_o and deq_queue_o SHALL hold their last values while deq_vld_o=0.
REQ-030 queue_nonempty_o SHALL reflect post-edge occupancy, registered with no combinational path from inputs.

Reset
REQ-031 When rst_n is low: all pointers and counts = 0, queue_nonempty_o = 0, deq_vld_o = 0, deq_err_o = 0, deq_address_o = 0, deq_queue_o = 0, drop_cnt_o = 0, desc_rdy_o = 0.
REQ-032 FIFO storage arrays SHALL NOT be reset.
REQ-033 Reset asserted mid-operation SHALL discard all queued descriptors; no deq_vld_o pulse SHALL follow release for requests made before reset.

Structure
REQ-034 Package tsn_queue_pkg SHALL hold NUM_Q, DEPTH, ADDR_W, QNUM_W=8, the descriptor width (24), and the descriptor field-slice constants.
REQ-035 One sub-module, desc_fifo (single FIFO: push, pop, head, count, full, empty), SHALL be instantiated NUM_Q times.
REQ-036 Top-level logic SHALL contain only push/pop decode, the drop counter, and the output register stage.

Verification
REQ-037 Reset, then enqueue {8'd3, 16'h1234}; deq_req q=3 -> next cycle deq_vld_o=1, deq_address_o=16'h1234, deq_queue_o=3; queue_nonempty_o[3] returns to 0.
REQ-038 Enqueue 9 descriptors to q=5 (addresses 0..8) -> drop_cnt_o=1; 8 dequeues return addresses 0..7 in order; 9th dequeue -> deq_err_o pulse.
REQ-039 Enqueue queue_number=8'd9 -> drop_cnt_o increments; queue_nonempty_o unchanged at 0.
REQ-040 Same-cycle enqueue and dequeue on empty q=0 -> deq_err_o=1, then queue_nonempty_o[0]=1; a following dequeue returns the stored address.
REQ-041 Fill q=2 to 8 entries, then same-cycle enqueue and dequeue on q=2 -> oldest entry returned, new entry dropped, drop_cnt_o +1, occupancy 7.
REQ-042 Assert rst_n low with 3 entries queued and a request outstanding -> after release, all outputs 0, no deq_vld_o pulse, queue_nonempty_o=0.

Source files
------------

// File: rtl/tsn_queue_pkg.sv
// Shared sizing constants and descriptor layout for the per-queue descriptor buffer.
package tsn_queue_pkg;

  localparam int unsigned NUM_Q  = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned QNUM_W = 8;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned DESC_W = QNUM_W + ADDR_W;

  // Descriptor field slices: {queue_number, bm_address}
  localparam int unsigned DESC_ADDR_LSB = 0;
  localparam int unsigned DESC_ADDR_MSB = ADDR_W - 1;
  localparam int unsigned DESC_QNUM_LSB = ADDR_W;
  localparam int unsigned DESC_QNUM_MSB = DESC_W - 1;

  typedef struct packed {
    logic [QNUM_W-1:0] qnum;
    logic [ADDR_W-1:0] addr;
  } desc_t;

endpackage

// File: rtl/desc_fifo.sv
// Single descriptor FIFO: wrapping pointers, explicit occupancy count, unreset storage.
module desc_fifo
  import tsn_queue_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = DEPTH,
  parameter  int unsigned DATA_W     = ADDR_W,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head_c,
  output logic [CNT_W-1:0]  count,
  output logic              full_c,
  output logic              empty_c
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full_c  = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  // Storage write; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/queue_desc_buffer.sv
// Per-queue descriptor buffer: routes enqueues to NUM_Q FIFOs, serves dequeues with 1-cycle latency.
module queue_desc_buffer #(
  parameter  int unsigned NUM_Q  = tsn_queue_pkg::NUM_Q,
  parameter  int unsigned DEPTH  = tsn_queue_pkg::DEPTH,
  parameter  int unsigned ADDR_W = tsn_queue_pkg::ADDR_W,
  localparam int unsigned QIDX_W = $clog2(NUM_Q),
  localparam int unsigned DESC_W = tsn_queue_pkg::QNUM_W + ADDR_W
) (
  input  logic                              clk_in,
  input  logic                              rst_n,
  input  logic [DESC_W-1:0]                 desc_i,
  input  logic                              desc_vld_i,
  output logic                              desc_rdy_o,
  input  logic                              deq_req_i,
  input  logic [QIDX_W-1:0]                 deq_queue_i,
  output logic                              deq_vld_o,
  output logic [ADDR_W-1:0]                 deq_address_o,
  output logic [QIDX_W-1:0]                 deq_queue_o,
  output logic                              deq_err_o,
  output logic [NUM_Q-1:0]                  queue_nonempty_o,
  output logic [tsn_queue_pkg::DROP_W-1:0]  drop_cnt_o
);
  import tsn_queue_pkg::QNUM_W;
  import tsn_queue_pkg::DROP_W;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [QNUM_W-1:0] qnum;
  logic [ADDR_W-1:0] addr_in;
  logic              accept;
  logic              drop;
  logic              deq_hit;
  logic              deq_miss;
  logic [NUM_Q-1:0]  push;
  logic [NUM_Q-1:0]  pop;
  logic [NUM_Q-1:0]  full;
  logic [NUM_Q-1:0]  empty;
  logic [NUM_Q-1:0]  nonempty_d;
  logic [ADDR_W-1:0] head  [NUM_Q];
  logic [CNT_W-1:0]  count [NUM_Q];

  assign qnum       = desc_i[ADDR_W +: QNUM_W];
  assign addr_in    = desc_i[ADDR_W-1:0];
  assign desc_rdy_o = rst_n;
  assign accept     = desc_vld_i & desc_rdy_o;

  // Push/pop decode on pre-edge occupancy; compute post-edge non-empty flags.
  always_comb begin
    push     = '0;
    pop      = '0;
    drop     = 1'b0;
    deq_hit  = 1'b0;
    deq_miss = 1'b0;
    if (accept) begin
      if ((32'(qnum) < NUM_Q) && !full[qnum[QIDX_W-1:0]]) begin
        push[qnum[QIDX_W-1:0]] = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (deq_req_i) begin
      if (empty[deq_queue_i]) begin
        deq_miss = 1'b1;
      end else begin
        deq_hit           = 1'b1;
        pop[deq_queue_i]  = 1'b1;
      end
    end
    for (int q = 0; q < NUM_Q; q++) begin
      nonempty_d[q] = push[q] | (~empty[q] & ~(pop[q] & (count[q] == CNT_W'(1))));
    end
  end

  for (genvar q = 0; q < NUM_Q; q++) begin : g_q
    desc_fifo #(
      .FIFO_DEPTH (DEPTH),
      .DATA_W     (ADDR_W)
    ) u_fifo (
      .clk     (clk_in),
      .rst_n   (rst_n),
      .push    (push[q]),
      .pop     (pop[q]),
      .din     (addr_in),
      .head_c  (head[q]),
      .count   (count[q]),
      .full_c  (full[q]),
      .empty_c (empty[q])
    );
  end

  // Saturating count of dropped descriptors.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + DROP_W'(1);
    end
  end

  // Dequeue result and status register stage; address/queue hold when idle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      deq_vld_o        <= 1'b0;
      deq_err_o        <= 1'b0;
      deq_address_o    <= '0;
      deq_queue_o      <= '0;
      queue_nonempty_o <= '0;
    end else begin
      deq_vld_o        <= deq_hit;
      deq_err_o        <= deq_miss;
      queue_nonempty_o <= nonempty_d;
      if (deq_hit) begin
        deq_address_o <= head[deq_queue_i];
        deq_queue_o   <= deq_queue_i;
      end
    end
  end

endmodule

// File: tb/tb_queue_desc_buffer.sv
// Scoreboard bench for queue_desc_buffer.
module tb_queue_desc_buffer;

  typedef struct {
    bit          err;
    logic [15:0] addr;
    logic [2:0]  q;
    int          due;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [23:0] desc_i = '0;
  logic        desc_vld_i = 1'b0;
  logic        desc_rdy_o;
  logic        deq_req_i = 1'b0;
  logic [2:0]  deq_queue_i = '0;
  logic        deq_vld_o;
  logic [15:0] deq_address_o;
  logic [2:0]  deq_queue_o;
  logic        deq_err_o;
  logic [7:0]  queue_nonempty_o;
  logic [15:0] drop_cnt_o;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          mdrop = 0;
  logic [15:0] mq [8][$];
  exp_t        sb [$];
  logic [15:0] last_addr = '0;
  logic [2:0]  last_q    = '0;

  queue_desc_buffer dut (
    .clk_in           (clk_in),
    .rst_n            (rst_n),
    .desc_i           (desc_i),
    .desc_vld_i       (desc_vld_i),
    .desc_rdy_o       (desc_rdy_o),
    .deq_req_i        (deq_req_i),
    .deq_queue_i      (deq_queue_i),
    .deq_vld_o        (deq_vld_o),
    .deq_address_o    (deq_address_o),
    .deq_queue_o      (deq_queue_o),
    .deq_err_o        (deq_err_o),
    .queue_nonempty_o (queue_nonempty_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_nonempty();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (mq[i].size() != 0);
    return r;
  endfunction

  // Output monitor: pops the scoreboard whenever the DUT reports a dequeue result.
  always @(negedge clk_in) begin : mon
    exp_t e;
    if (rst_n) begin
      if (deq_vld_o || deq_err_o) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'({deq_vld_o, deq_err_o}), 32'd0);
        end else begin
          e = sb.pop_front();
          check("deq_latency", 32'(cyc), 32'(e.due));
          check("deq_flags", 32'({deq_vld_o, deq_err_o}), e.err ? 32'd1 : 32'd2);
          if (!e.err) begin
            check("deq_addr", 32'(deq_address_o), 32'(e.addr));
            check("deq_queue", 32'(deq_queue_o), 32'(e.q));
            last_addr = e.addr;
            last_q    = e.q;
          end else begin
            check("hold_on_err", 32'({deq_queue_o, deq_address_o}), 32'({last_q, last_addr}));
          end
        end
      end else begin
        check("hold_idle", 32'({deq_queue_o, deq_address_o}), 32'({last_q, last_addr}));
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          check("deq_missing", 32'({deq_vld_o, deq_err_o}), e.err ? 32'd1 : 32'd2);
        end
      end
    end
  end

  // One clock of stimulus; model is updated from pre-edge state.
  task automatic step(input bit ev, input logic [7:0] qn, input logic [15:0] addr,
                      input bit dr, input logic [2:0] dq);
    exp_t e;
    bit   enq_ok;
    desc_vld_i  = ev;
    desc_i      = {qn, addr};
    deq_req_i   = dr;
    deq_queue_i = dq;
    enq_ok = ev && (qn < 8) && (mq[qn[2:0]].size() < 8);
    if (ev && !enq_ok && mdrop < 65535) mdrop++;
    if (dr) begin
      e.due = cyc + 1;
      e.q   = dq;
      if (mq[dq].size() == 0) begin
        e.err  = 1'b1;
        e.addr = '0;
      end else begin
        e.err  = 1'b0;
        e.addr = mq[dq].pop_front();
      end
      sb.push_back(e);
    end
    if (enq_ok) mq[qn[2:0]].push_back(addr);
    @(posedge clk_in);
    @(negedge clk_in);
    desc_vld_i = 1'b0;
    deq_req_i  = 1'b0;
    check("drop_cnt", 32'(drop_cnt_o), 32'(mdrop));
    check("nonempty", 32'(queue_nonempty_o), 32'(model_nonempty()));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"},  32'(deq_vld_o), 32'd0);
    check({tag, "_err"},  32'(deq_err_o), 32'd0);
    check({tag, "_addr"}, 32'(deq_address_o), 32'd0);
    check({tag, "_q"},    32'(deq_queue_o), 32'd0);
    check({tag, "_ne"},   32'(queue_nonempty_o), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk_in);
    check_reset_outputs("rst");
    check("rst_rdy", 32'(desc_rdy_o), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_after_rst", 32'(desc_rdy_o), 32'd1);
    @(negedge clk_in);

    // Single enqueue/dequeue on q3
    step(1, 8'd3, 16'h1234, 0, 3'd0);
    step(0, 8'd0, 16'h0000, 1, 3'd3);
    step(0, 8'd0, 16'h0000, 0, 3'd0);

    // Overfill q5, then drain in order plus one underflow
    for (int i = 0; i < 9; i++) step(1, 8'd5, 16'(i), 0, 3'd0);
    for (int i = 0; i < 9; i++) step(0, 8'd0, 16'h0000, 1, 3'd5);

    // Out-of-range queue number
    step(1, 8'd9, 16'hDEAD, 0, 3'd0);

    // Same-cycle enqueue/dequeue on empty q0: error, entry kept
    step(1, 8'd0, 16'hABCD, 1, 3'd0);
    step(0, 8'd0, 16'h0000, 1, 3'd0);

    // Full q2 with simultaneous enqueue/dequeue: enqueue dropped
    for (int i = 0; i < 8; i++) step(1, 8'd2, 16'h0200 + 16'(i), 0, 3'd0);
    step(1, 8'd2, 16'h02FF, 1, 3'd2);
    for (int i = 0; i < 8; i++) step(0, 8'd0, 16'h0000, 1, 3'd2);

    // Concurrent traffic on different queues
    step(1, 8'd4, 16'h4444, 0, 3'd0);
    step(1, 8'd6, 16'h6666, 1, 3'd4);
    step(1, 8'd6, 16'h6667, 1, 3'd6);
    step(0, 8'd0, 16'h0000, 1, 3'd6);

    // Random mixed traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 16'($urandom),
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
    for (int q = 0; q < 8; q++) begin
      while (mq[q].size() > 0) step(0, 8'd0, 16'h0000, 1, 3'(q));
    end
    step(0, 8'd0, 16'h0000, 0, 3'd0);

    // Reset with entries queued and a dequeue in flight
    for (int i = 0; i < 3; i++) step(1, 8'd1, 16'hA000 + 16'(i), 0, 3'd0);
    step(1, 8'd9, 16'h0BAD, 0, 3'd0);
    deq_req_i   = 1'b1;
    deq_queue_i = 3'd1;
    @(posedge clk_in);
    #1;
    rst_n     = 1'b0;
    deq_req_i = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) mq[i].delete();
    mdrop     = 0;
    last_addr = '0;
    last_q    = '0;
    @(negedge clk_in);
    check_reset_outputs("midrst");
    check("midrst_rdy", 32'(desc_rdy_o), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) step(0, 8'd0, 16'h0000, 0, 3'd0);
    check_reset_outputs("post_rst");

    // Queue 1 must start clean after reset
    step(1, 8'd1, 16'hBEEF, 0, 3'd0);
    step(0, 8'd0, 16'h0000, 1, 3'd1);
    step(0, 8'd0, 16'h0000, 1, 3'd1);
    step(0, 8'd0, 16'h0000, 0, 3'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
